// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 raster constants, scan flag bundle and pixel colour expansion
// for the video scan controller.
package video_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

  localparam int SRC_W = 320;
  localparam int SRC_H = 240;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic frame_start;
    logic line_start;
  } scan_flags_t;

  function automatic logic [23:0] rgb444_to_rgb888(input logic [11:0] rgb444);
    return {rgb444[11:8], rgb444[11:8], rgb444[7:4], rgb444[7:4],
            rgb444[3:0], rgb444[3:0]};
  endfunction

endpackage

// File: rtl/video_scan_ctrl_sync_delay.sv
// Reset-cleared shift register that holds the scan flags back until the source pixel
// is ready; tap_o is the value about to enter the last stage.
module sync_delay #(
  parameter int               WIDTH   = 5,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] tap_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift chain, cleared to the idle flag pattern on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

  generate
    if (DEPTH == 1) begin : g_single
      assign tap_o = d_i;
    end else begin : g_chain
      assign tap_o = stage_q[DEPTH-2];
    end
  endgenerate

endmodule

// File: rtl/video_scan_ctrl.sv
// VGA raster master: issues half-resolution source coordinates and returns the
// sampled pixel as RGB888 aligned with sync and data-enable.
module video_scan_ctrl
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter int   SRC_LAT  = 0,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [8:0]  h_count,
  output logic [8:0]  v_count,
  input  logic [15:0] bg_data,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic        vid_de,
  output logic [23:0] vid_rgb,
  output logic        frame_start,
  output logic        line_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam scan_flags_t FLAGS_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, de: 1'b0,
                                         frame_start: 1'b0, line_start: 1'b0};

  logic [9:0]  hc_q, hc_d, vc_q, vc_d;
  logic [8:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  scan_flags_t flags_q, flags_d, tap_flags_s, out_flags_s;
  logic [23:0] rgb_q, rgb_d;
  logic        active_s;
  logic        unused_s;

  // Next raster position; the frame wraps straight back to 0,0
  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == 10'(H_TOTAL - 1)) begin
      hc_d = 10'd0;
      if (vc_q == 10'(V_TOTAL - 1)) begin
        vc_d = 10'd0;
      end else begin
        vc_d = vc_q + 10'd1;
      end
    end else begin
      hc_d = hc_q + 10'd1;
    end
  end

  // Raster counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc_q <= 10'd0;
      vc_q <= 10'd0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // Outside the active area the source sees an out-of-range coordinate and returns black
  always_comb begin
    active_s = (hc_q < 10'(H_ACTIVE)) && (vc_q < 10'(V_ACTIVE));
    flags_d  = FLAGS_IDLE;
    h_cnt_d  = 9'(SRC_W);
    v_cnt_d  = 9'(SRC_H);
    if (active_s) begin
      h_cnt_d             = hc_q[9:1];
      v_cnt_d             = vc_q[9:1];
      flags_d.de          = 1'b1;
      flags_d.line_start  = (hc_q == 10'd0);
      flags_d.frame_start = (hc_q == 10'd0) && (vc_q == 10'd0);
    end else begin
      flags_d.de = 1'b0;
    end
    if ((hc_q >= 10'(HS_START)) && (hc_q <= 10'(HS_END))) begin
      flags_d.hsync = SYNC_POL;
    end else begin
      flags_d.hsync = ~SYNC_POL;
    end
    if ((vc_q >= 10'(VS_START)) && (vc_q <= 10'(VS_END))) begin
      flags_d.vsync = SYNC_POL;
    end else begin
      flags_d.vsync = ~SYNC_POL;
    end
  end

  // Coordinate register together with the flags that belong to it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= 9'(SRC_W);
      v_cnt_q <= 9'(SRC_H);
      flags_q <= FLAGS_IDLE;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      flags_q <= flags_d;
    end
  end

  sync_delay #(
    .WIDTH  ($bits(scan_flags_t)),
    .DEPTH  (SRC_LAT + 1),
    .RST_VAL(FLAGS_IDLE)
  ) u_sync_delay (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (flags_q),
    .q_o   (out_flags_s),
    .tap_o (tap_flags_s)
  );

  // Pixel is gated with the de that lands on the output in the same cycle
  always_comb begin
    if (tap_flags_s.de) begin
      rgb_d = rgb444_to_rgb888(bg_data[11:0]);
    end else begin
      rgb_d = 24'd0;
    end
  end

  // Output pixel register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= 24'd0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign unused_s = ^{bg_data[15:12], tap_flags_s.hsync, tap_flags_s.vsync,
                      tap_flags_s.frame_start, tap_flags_s.line_start};

  assign h_count     = h_cnt_q;
  assign v_count     = v_cnt_q;
  assign vid_hsync   = out_flags_s.hsync;
  assign vid_vsync   = out_flags_s.vsync;
  assign vid_de      = out_flags_s.de;
  assign frame_start = out_flags_s.frame_start;
  assign line_start  = out_flags_s.line_start;
  assign vid_rgb     = rgb_q;

endmodule
